// File: rtl/fht_bank_writer_if.sv
// Bank write-back bus of the FHT datapath: butterfly results in, bank write port and stage status out.
interface fht_bank_writer_if #(
  parameter int unsigned D_BIT   = 17,
  parameter int unsigned A_BIT   = 8,
  parameter int unsigned SEC_BIT = 4
);

  logic                      iSTART;
  logic [SEC_BIT-1:0]        iSTAGE;
  logic                      iVALID;
  logic                      iSWAP;
  logic signed [D_BIT-1:0]   iY_0;
  logic signed [D_BIT-1:0]   iY_1;
  logic signed [D_BIT-1:0]   iY_2;
  logic signed [D_BIT-1:0]   iY_3;

  logic                      oWE;
  logic [A_BIT-1:0]          oADDR;
  logic signed [D_BIT-1:0]   oD_0;
  logic signed [D_BIT-1:0]   oD_1;
  logic signed [D_BIT-1:0]   oD_2;
  logic signed [D_BIT-1:0]   oD_3;
  logic                      oBUSY;
  logic                      oDONE;
  logic                      oOVF;

  // Sequencer / butterfly side
  modport master (
    output iSTART, iSTAGE, iVALID, iSWAP, iY_0, iY_1, iY_2, iY_3,
    input  oWE, oADDR, oD_0, oD_1, oD_2, oD_3, oBUSY, oDONE, oOVF
  );

  // Bank writer side
  modport slave (
    input  iSTART, iSTAGE, iVALID, iSWAP, iY_0, iY_1, iY_2, iY_3,
    output oWE, oADDR, oD_0, oD_1, oD_2, oD_3, oBUSY, oDONE, oOVF
  );

endinterface

// File: rtl/fht_bank_writer.sv
// FHT write-back: one word per bank per beat, per-stage beat counting and stage-done pulse.
// Optional FHT_WR_BITREV_EN: stage 0 writes to bit-reversed addresses (input reordering).
module fht_bank_writer #(
  parameter int unsigned D_BIT   = 17,
  parameter int unsigned A_BIT   = 8,
  parameter int unsigned SEC_BIT = 4
) (
  input  logic               iCLK,
  input  logic               iRESET,
  fht_bank_writer_if.slave   bus
);

  localparam logic [A_BIT-1:0] LAST_BEAT = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_LAST  = 2'd2
  } state_t;

  typedef struct packed {
    logic [A_BIT-1:0] addr;
    logic [D_BIT-1:0] d0;
    logic [D_BIT-1:0] d1;
    logic [D_BIT-1:0] d2;
    logic [D_BIT-1:0] d3;
  } wr_t;

  state_t             state_q, state_d;
  logic [A_BIT-1:0]   cnt_q, cnt_d;
  logic [SEC_BIT-1:0] stage_q, stage_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic               we_q, we_d;
  wr_t                wr_q, wr_d;

  logic               beat_c;
  logic [A_BIT-1:0]   beat_idx_c;
  logic [A_BIT-1:0]   beat_addr_c;

`ifdef FHT_WR_BITREV_EN
  logic [SEC_BIT-1:0] beat_stage_c;

  function automatic logic [A_BIT-1:0] bit_rev(input logic [A_BIT-1:0] a);
    logic [A_BIT-1:0] r;
    r = '0;
    for (int i = 0; i < int'(A_BIT); i++) begin
      r[i] = a[int'(A_BIT) - 1 - i];
    end
    return r;
  endfunction
`endif

  // A start always restarts the beat count, so a same-cycle beat is beat 0 of the new stage
  always_comb begin
    beat_c      = bus.iVALID && (bus.iSTART || (state_q == S_WRITE));
    beat_idx_c  = bus.iSTART ? '0 : cnt_q;
`ifdef FHT_WR_BITREV_EN
    beat_stage_c = bus.iSTART ? bus.iSTAGE : stage_q;
    beat_addr_c  = (beat_stage_c == '0) ? bit_rev(beat_idx_c) : beat_idx_c;
`else
    beat_addr_c  = beat_idx_c;
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    we_d    = 1'b0;
    wr_d    = wr_q;

    if (bus.iSTART) begin
      state_d = S_WRITE;
      cnt_d   = '0;
      stage_d = bus.iSTAGE;
      busy_d  = 1'b1;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.iVALID) ovf_d = 1'b1;
        end
        S_WRITE: begin
        end
        S_LAST: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
          if (bus.iVALID) ovf_d = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end

    if (beat_c) begin
      we_d      = 1'b1;
      wr_d.addr = beat_addr_c;
      wr_d.d0   = bus.iY_0;
      wr_d.d1   = bus.iSWAP ? bus.iY_2 : bus.iY_1;
      wr_d.d2   = bus.iSWAP ? bus.iY_1 : bus.iY_2;
      wr_d.d3   = bus.iY_3;
      cnt_d     = beat_idx_c + A_BIT'(1);
      if (beat_idx_c == LAST_BEAT) begin
        state_d = S_LAST;
        done_d  = 1'b1;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      we_q    <= we_d;
      wr_q    <= wr_d;
    end
  end

  assign bus.oWE   = we_q;
  assign bus.oADDR = wr_q.addr;
  assign bus.oD_0  = wr_q.d0;
  assign bus.oD_1  = wr_q.d1;
  assign bus.oD_2  = wr_q.d2;
  assign bus.oD_3  = wr_q.d3;
  assign bus.oBUSY = busy_q;
  assign bus.oDONE = done_q;
  assign bus.oOVF  = ovf_q;

endmodule

// File: tb/tb_fht_bank_writer.sv
// Scoreboard bench for fht_bank_writer at A_BIT=3 (8 beats per stage).
module tb_fht_bank_writer;

  localparam int unsigned D_BIT   = 17;
  localparam int unsigned A_BIT   = 3;
  localparam int unsigned SEC_BIT = 4;
  localparam int          BEATS   = 8;
`ifdef FHT_WR_BITREV_EN
  localparam bit BITREV = 1'b1;
`else
  localparam bit BITREV = 1'b0;
`endif

  typedef struct packed {
    logic [A_BIT-1:0] addr;
    logic [D_BIT-1:0] d0;
    logic [D_BIT-1:0] d1;
    logic [D_BIT-1:0] d2;
    logic [D_BIT-1:0] d3;
    logic             done;
  } exp_t;

  logic clk;
  logic rst_n;
  logic mon_en;
  int   n_checks;
  int   n_pass;
  exp_t exp_q[$];

  fht_bank_writer_if #(.D_BIT(D_BIT), .A_BIT(A_BIT), .SEC_BIT(SEC_BIT)) bus ();

  fht_bank_writer #(.D_BIT(D_BIT), .A_BIT(A_BIT), .SEC_BIT(SEC_BIT)) dut (
    .iCLK   (clk),
    .iRESET (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [A_BIT-1:0] exp_addr(input int k, input int stage);
    logic [A_BIT-1:0] kk;
    kk = A_BIT'(k);
    return (BITREV && stage == 0) ? {kk[0], kk[1], kk[2]} : kk;
  endfunction

  // Drive one cycle of inputs; push the expected write when the beat should be accepted
  task automatic drive(input logic start, input int stage, input logic valid,
                       input logic swap, input int k, input int base, input logic accept);
    exp_t e;
    logic [D_BIT-1:0] y0, y1, y2, y3;
    y0 = D_BIT'(base + k);
    y1 = D_BIT'(base + 10 + k);
    y2 = D_BIT'(base + 20 + k);
    y3 = D_BIT'(base + 30 + k);
    bus.iSTART = start;
    bus.iSTAGE = SEC_BIT'(stage);
    bus.iVALID = valid;
    bus.iSWAP  = swap;
    bus.iY_0   = y0;
    bus.iY_1   = y1;
    bus.iY_2   = y2;
    bus.iY_3   = y3;
    if (accept) begin
      e.addr = exp_addr(k, stage);
      e.d0   = y0;
      e.d1   = swap ? y2 : y1;
      e.d2   = swap ? y1 : y2;
      e.d3   = y3;
      e.done = (k == BEATS - 1);
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.iSTART = 1'b0;
    bus.iVALID = 1'b0;
    bus.iSWAP  = 1'b0;
  endtask

  // Write monitor: every oWE must match the oldest expected write
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t act;
      exp_t e;
      n_checks++;
      if (bus.oWE === 1'b1) begin
        act.addr = bus.oADDR;
        act.d0   = bus.oD_0;
        act.d1   = bus.oD_1;
        act.d2   = bus.oD_2;
        act.d3   = bus.oD_3;
        act.done = bus.oDONE;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_write: got addr=%0d done=%b, required no write", act.addr, act.done);
        end else begin
          e = exp_q.pop_front();
          if (act !== e)
            $display("FAIL write: got addr=%0d d=%h/%h/%h/%h done=%b, required addr=%0d d=%h/%h/%h/%h done=%b",
                     act.addr, act.d0, act.d1, act.d2, act.d3, act.done,
                     e.addr, e.d0, e.d1, e.d2, e.d3, e.done);
          else
            n_pass++;
        end
      end else begin
        if (bus.oDONE !== 1'b0 || bus.oWE !== 1'b0)
          $display("FAIL idle_cycle: got we=%b done=%b, required we=0 done=0", bus.oWE, bus.oDONE);
        else
          n_pass++;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.oWE !== 1'b0 || bus.oDONE !== 1'b0) $display("FAIL reset_we_done: got %b%b, required 00", bus.oWE, bus.oDONE);
    else n_pass++;
    n_checks++;
    if (bus.oADDR !== '0) $display("FAIL reset_addr: got %0d, required 0", bus.oADDR);
    else n_pass++;
    n_checks++;
    if ({bus.oD_0, bus.oD_1, bus.oD_2, bus.oD_3} !== '0) $display("FAIL reset_data: got nonzero, required 0");
    else n_pass++;
    n_checks++;
    if (bus.oBUSY !== 1'b0 || bus.oOVF !== 1'b0) $display("FAIL reset_busy_ovf: got %b%b, required 00", bus.oBUSY, bus.oOVF);
    else n_pass++;
    rst_n  = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_linear();
    drive(1'b1, 2, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++;
    if (bus.oBUSY !== 1'b1) $display("FAIL linear_busy_start: got %b, required 1", bus.oBUSY);
    else n_pass++;
    for (int k = 0; k < BEATS; k++) drive(1'b0, 2, 1'b1, 1'b0, k, 0, 1'b1);
    n_checks++;
    if (bus.oBUSY !== 1'b1) $display("FAIL linear_busy_last: got %b, required 1", bus.oBUSY);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.oBUSY !== 1'b0) $display("FAIL linear_busy_end: got %b, required 0", bus.oBUSY);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL linear_pending: got %0d, required 0", exp_q.size());
    else n_pass++;
  endtask

  // Start and first beat in the same idle cycle, swap only on beat 3
  task automatic test_swap();
    drive(1'b1, 2, 1'b1, 1'b0, 0, 0, 1'b1);
    for (int k = 1; k < BEATS; k++) drive(1'b0, 2, 1'b1, (k == 3), k, 0, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.oOVF !== 1'b0 || bus.oBUSY !== 1'b0) $display("FAIL swap_end: got ovf=%b busy=%b, required 0 0", bus.oOVF, bus.oBUSY);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL swap_pending: got %0d, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_gapped();
    int k;
    k = 0;
    drive(1'b1, 5, 1'b0, 1'b0, 0, -50, 1'b0);
    for (int i = 0; k < BEATS; i++) begin
      if (i % 3 == 0) begin
        drive(1'b0, 5, 1'b1, 1'b0, k, -50, 1'b1);
        k++;
      end else begin
        drive(1'b0, 5, 1'b0, 1'b0, k, -50, 1'b0);
      end
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || bus.oBUSY !== 1'b0) $display("FAIL gapped_end: got pending=%0d busy=%b, required 0 0", exp_q.size(), bus.oBUSY);
    else n_pass++;
  endtask

  task automatic test_ovf();
    drive(1'b0, 0, 1'b1, 1'b0, 0, 7, 1'b0);
    n_checks++;
    if (bus.oOVF !== 1'b1) $display("FAIL ovf_idle_set: got %b, required 1", bus.oOVF);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.oOVF !== 1'b1) $display("FAIL ovf_sticky: got %b, required 1", bus.oOVF);
    else n_pass++;
    drive(1'b1, 1, 1'b0, 1'b0, 0, 7, 1'b0);
    n_checks++;
    if (bus.oOVF !== 1'b0) $display("FAIL ovf_clear_on_start: got %b, required 0", bus.oOVF);
    else n_pass++;
    for (int k = 0; k < BEATS; k++) drive(1'b0, 1, 1'b1, 1'b0, k, 7, 1'b1);
    drive(1'b0, 1, 1'b1, 1'b0, 0, 7, 1'b0);
    n_checks++;
    if (bus.oOVF !== 1'b1 || bus.oBUSY !== 1'b0) $display("FAIL ovf_last_beat: got ovf=%b busy=%b, required 1 0", bus.oOVF, bus.oBUSY);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  // New stage started in the LAST cycle together with its first beat
  task automatic test_back_to_back();
    drive(1'b1, 3, 1'b0, 1'b0, 0, 100, 1'b0);
    for (int k = 0; k < BEATS; k++) drive(1'b0, 3, 1'b1, 1'b0, k, 100, 1'b1);
    drive(1'b1, 4, 1'b1, 1'b1, 0, 200, 1'b1);
    n_checks++;
    if (bus.oBUSY !== 1'b1) $display("FAIL b2b_busy: got %b, required 1", bus.oBUSY);
    else n_pass++;
    for (int k = 1; k < BEATS; k++) drive(1'b0, 4, 1'b1, 1'b0, k, 200, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || bus.oBUSY !== 1'b0) $display("FAIL b2b_end: got pending=%0d busy=%b, required 0 0", exp_q.size(), bus.oBUSY);
    else n_pass++;
  endtask

  task automatic test_restart();
    drive(1'b1, 2, 1'b0, 1'b0, 0, 40, 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b0, 2, 1'b1, 1'b0, k, 40, 1'b1);
    drive(1'b1, 2, 1'b0, 1'b0, 0, 60, 1'b0);
    for (int k = 0; k < BEATS; k++) drive(1'b0, 2, 1'b1, 1'b0, k, 60, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || bus.oBUSY !== 1'b0) $display("FAIL restart_end: got pending=%0d busy=%b, required 0 0", exp_q.size(), bus.oBUSY);
    else n_pass++;

    drive(1'b1, 2, 1'b0, 1'b0, 0, 80, 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b0, 2, 1'b1, 1'b0, k, 80, 1'b1);
    bus.iVALID = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.oWE !== 1'b0 || bus.oBUSY !== 1'b0 || bus.oDONE !== 1'b0 || bus.oADDR !== '0 || bus.oD_0 !== '0)
      $display("FAIL async_reset: got we=%b busy=%b done=%b addr=%0d d0=%h, required all 0",
               bus.oWE, bus.oBUSY, bus.oDONE, bus.oADDR, bus.oD_0);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL reset_pending: got %0d, required 0", exp_q.size());
    else n_pass++;
    bus.iVALID = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 6, 1'b0, 1'b0, 0, -9, 1'b0);
    for (int k = 0; k < BEATS; k++) drive(1'b0, 6, 1'b1, 1'b0, k, -9, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL post_reset_pending: got %0d, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_bitrev();
    for (int s = 0; s < 2; s++) begin
      drive(1'b1, s, 1'b0, 1'b0, 0, 300, 1'b0);
      for (int k = 0; k < BEATS; k++) drive(1'b0, s, 1'b1, 1'b0, k, 300, 1'b1);
      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL bitrev_pending: stage %0d got %0d, required 0", s, exp_q.size());
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    mon_en     = 1'b0;
    rst_n      = 1'b0;
    bus.iSTART = 1'b0;
    bus.iSTAGE = '0;
    bus.iVALID = 1'b0;
    bus.iSWAP  = 1'b0;
    bus.iY_0   = '0;
    bus.iY_1   = '0;
    bus.iY_2   = '0;
    bus.iY_3   = '0;
    @(negedge clk);
    test_reset();
    test_linear();
    test_swap();
    test_gapped();
    test_ovf();
    test_back_to_back();
    test_restart();
    test_bitrev();
    mon_en = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fht_bank_writer.md
Name: fht_bank_writer

Overview:
Write-back side of the FHT datapath: takes the four registered butterfly results of each beat (Y_0..Y_3) and writes one word into each of the four RAM banks per beat. It generates bank write addresses, write enables and the optional bank swap, counts beats per stage, and signals stage completion to the stage sequencer. It mirrors the bank-read path feeding the butterfly block.

Parameters:
D_BIT, 17, data word width (matches butterfly output width)
A_BIT, 8, bank address width; one stage = 2^A_BIT beats
SEC_BIT, 4, stage index width

Ports:
iCLK  in  1  clock
iRESET  in  1  asynchronous active-low reset
iSTART  in  1  one-cycle pulse: begin a new stage
iSTAGE  in  SEC_BIT  stage index, sampled on iSTART
iVALID  in  1  Y inputs valid this cycle (one beat)
iSWAP  in  1  swap Y_1/Y_2 bank destinations for this beat
iY_0..iY_3  in  D_BIT each  butterfly results, signed
oWE  out  1  write enable, common to all four banks
oADDR  out  A_BIT  bank write address
oD_0..oD_3  out  D_BIT each  bank write data, banks 0..3
oBUSY  out  1  stage in progress
oDONE  out  1  one-cycle pulse with the final write of a stage
oOVF  out  1  sticky: beat received while not in a stage

Behaviour:
- Reset: iRESET async, active-low; clock iCLK. All outputs 0, state IDLE, beat counter 0, stored stage 0.
- States: IDLE, WRITE, LAST.
- IDLE: iSTART -> WRITE, counter <= 0, stage <= iSTAGE, oOVF <= 0, oBUSY <= 1. iVALID without iSTART -> oOVF <= 1, no write.
- WRITE: each iVALID cycle is one beat; all outputs registered, latency 1: next cycle oWE=1, oADDR=address(counter), oD_0=iY_0, oD_3=iY_3, oD_1/oD_2 = iY_1/iY_2, or iY_2/iY_1 when iSWAP=1. Counter increments per beat. iVALID=0 -> oWE=0 next cycle, data/address hold last values.
- Beat at counter = 2^A_BIT-1 -> state LAST; that write appears next cycle together with oDONE=1 and oBUSY still 1.
- LAST: one cycle; oDONE=1, then -> IDLE, oBUSY <= 0, counter <= 0. iVALID in LAST sets oOVF, not written. iSTART in LAST is honoured (-> WRITE directly, oBUSY stays 1).
- Address: address(k) = k (unsigned, wraps naturally at 2^A_BIT). Counter never exceeds 2^A_BIT-1.
- iSTART during WRITE: restart; counter <= 0, stage reloaded, no oDONE for the aborted stage, beat with same-cycle iVALID is written as beat 0 of the new stage.
- iSTART and iVALID in same IDLE cycle: start accepted and that beat written as beat 0 (no oOVF).
- oWE is 0 in every cycle not following an accepted beat. Async reset mid-stage: immediate return to reset values, no further writes.

Optional Feature:
FHT_WR_BITREV_EN: when defined, if stored stage = 0 the address is the A_BIT-bit bit-reversal of the counter (input reordering for stage 0); other stages linear. When undefined, all stages use linear address; stage index stored but unused for addressing.

Test Plan:
A_BIT=3: iSTART (iSTAGE=2), 8 consecutive beats iY_0=k, iY_1=10+k, iY_2=20+k, iY_3=30+k, iSWAP=0 -> oWE on 8 cycles, oADDR 0..7, oD_1=10+k; oDONE=1 only with addr 7; then oBUSY=0.
Same stage with iSWAP=1 on beat 3 only -> at addr 3 oD_1=23, oD_2=13; other beats unswapped.
Gapped iVALID (1,0,0,1,...) -> oWE only after valid beats, addresses contiguous, oDONE after 8th beat.
iVALID while IDLE -> oOVF=1, oWE=0; next iSTART clears oOVF.
iSTART after 4 beats -> counter restarts, next write addr 0, no oDONE until 8 beats of new stage; iRESET low at beat 5 -> all outputs 0 same cycle.
FHT_WR_BITREV_EN defined, iSTAGE=0 -> oADDR sequence 0,4,2,6,1,5,3,7; iSTAGE=1 -> 0..7.
